cr_gen_sequencer: RTL

//  Command-driven sequencer for the correlated-random PRNG datapath. Accepts {mode, width, count}, reseeds the

---
 rtl/cr_gen_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/cr_gen_sequencer.sv
// cr_gen_sequencer: command-driven sequencer that reseeds the PRNG core and streams lane-masked words downstream
module cr_gen_sequencer #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_mode_i,
  input  logic [2:0]        cmd_width_i,
  input  logic [CNT_W-1:0]  cmd_count_i,
  input  logic              abort_i,
  output logic              prng_seed_o,
  input  logic              prng_seed_ack_i,
  output logic              prng_req_o,
  input  logic              prng_valid_i,
  input  logic [DATA_W-1:0] prng_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [7:0]        out_keep_o,
  output logic [DATA_W-1:0] out_carry_mask_o,
  output logic [2:0]        out_mode_o,
  output logic              out_last_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] width;
  logic [CNT_W-1:0] rem;
  logic [1:0] sh;
  logic [3:0] lanes, n;
  logic legal, accept, cap, acc, abort;
  assign sh          = width == 3'b001 ? 2'd1 : width == 3'b011 ? 2'd2 : width == 3'b111 ? 2'd3 : 2'd0;
  assign lanes       = 4'd8 >> sh;
  assign n           = rem < CNT_W'(lanes) ? rem[3:0] : lanes;
  assign legal       = cmd_width_i inside {3'b000, 3'b001, 3'b011, 3'b111};
  assign cmd_ready_o = state == IDLE;
  assign prng_seed_o = state == SEED;
  assign done_o      = state == DONE;
  assign prng_req_o  = state == RUN && !out_valid_o && rem != '0;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign cap         = prng_req_o && prng_valid_i;
  assign acc         = out_valid_o && out_ready_i;
  assign abort       = abort_i && state != IDLE;
  // carry propagates across every 32-bit slice boundary that falls inside a lane
  always_comb begin
    out_carry_mask_o = '0;
    for (int k = 1; k < 8; k++) out_carry_mask_o[32*k] = (3'(k) & ((3'd1 << sh) - 3'd1)) != 3'd0;
  end
  // next-state decode, abort taking priority over all progress
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (state == IDLE && accept && legal) state_nx = cmd_count_i == '0 ? DONE : SEED;
    else if (state == SEED && prng_seed_ack_i) state_nx = RUN;
    else if (state == RUN && acc && out_last_o) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // command latch, remaining count and output word register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      width       <= '0;
      out_mode_o  <= '0;
      rem         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_keep_o  <= '0;
      out_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= accept && !legal;
      if (accept) begin
        width      <= cmd_width_i;
        out_mode_o <= cmd_mode_i;
        rem        <= cmd_count_i;
      end
      if (abort) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
        rem         <= '0;
      end else if (cap) begin
        out_data_o  <= prng_data_i;
        out_keep_o  <= 8'((9'd1 << (n << sh)) - 9'd1);
        out_last_o  <= rem == CNT_W'(n);
        rem         <= rem - CNT_W'(n);
        out_valid_o <= 1'b1;
      end else if (acc) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end
    end
  end
endmodule
